// File: rtl/symbol_stream_pkg.sv
// Shared types and elaboration helpers for the symbol stream source.
package symbol_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int unsigned syms_per_word(input int unsigned word_w,
                                                input int unsigned sym_w);
    return word_w / sym_w;
  endfunction

  // Word must split evenly into symbols, pacing must be at least one cycle,
  // and the FIFO depth must be a power of two for the wrap-bit pointers.
  function automatic bit params_ok(input int unsigned word_w,
                                   input int unsigned sym_w,
                                   input int unsigned rate,
                                   input int unsigned depth);
    return (sym_w != 0) && ((word_w % sym_w) == 0) && (rate >= 1) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; full/empty come from pointers with a wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en && !full_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en && !empty_c) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en && !full_c) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/symbol_stream_src.sv
// Paced MSB-first symbol source fed from a word FIFO, with run length and completion pulse.
// Optional stall counter output enabled by defining SYM_STREAM_STATS_EN.
module symbol_stream_src
  import symbol_stream_pkg::*;
#(
  parameter int unsigned SYM_W  = 2,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned RATE   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  seq_len,
  input  logic              wr_valid,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [SYM_W-1:0]  symbol,
  output logic              sym_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sym_count
`ifdef SYM_STREAM_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  localparam int unsigned SPW    = syms_per_word(WORD_W, SYM_W);
  localparam int unsigned SC_W   = $clog2(SPW + 1);
  localparam int unsigned PACE_W = (RATE > 1) ? $clog2(RATE) : 1;

  if (!params_ok(WORD_W, SYM_W, RATE, DEPTH)) begin : g_param_check
    $error("symbol_stream_src: invalid SYM_W/WORD_W/RATE/DEPTH combination");
  end

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sh_word_q;
  logic [SC_W-1:0]   sh_cnt_q;
  logic [PACE_W-1:0] pace_q;
  logic [CNT_W-1:0]  seq_len_q;
  logic [CNT_W-1:0]  sym_count_q;

  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [WORD_W-1:0] fifo_data_c;
  logic              wr_en_c;
  logic              accept_c;
  logic              start_c;
  logic              final_c;
  logic              load_c;
  logic              at_last_c;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en     (wr_en_c),
    .wr_data   (wr_data),
    .rd_en     (load_c),
    .rd_data_c (fifo_data_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  assign wr_ready  = !fifo_full_c;
  assign wr_en_c   = wr_valid && !fifo_full_c;
  assign at_last_c = (sym_count_q == seq_len_q - CNT_W'(1));
  assign sym_valid = (state_q == RUN) && (sh_cnt_q != '0) && (pace_q == '0);
  assign symbol    = sym_valid ? sh_word_q[WORD_W-1 -: SYM_W] : '0;
  assign sym_last  = sym_valid && at_last_c;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign sym_count = sym_count_q;

  // Next state plus the per-cycle strobes; the final accept never refills the shifter
  // so the following word stays in the FIFO for the next run.
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    final_c  = 1'b0;
    load_c   = 1'b0;
    accept_c = sym_valid && sym_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_c = 1'b1;
          state_d = (seq_len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (accept_c && at_last_c) begin
          final_c = 1'b1;
          state_d = FIN;
        end
        if (!fifo_empty_c && !final_c &&
            ((sh_cnt_q == '0) || (accept_c && (sh_cnt_q == SC_W'(1))))) begin
          load_c = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seq_len_q   <= '0;
      sym_count_q <= '0;
    end else if (start_c) begin
      seq_len_q   <= seq_len;
      sym_count_q <= '0;
    end else if (accept_c) begin
      sym_count_q <= sym_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                pace_q <= '0;
    else if (accept_c)      pace_q <= PACE_W'(RATE - 1);
    else if (pace_q != '0)  pace_q <= pace_q - PACE_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_word_q <= '0;
      sh_cnt_q  <= '0;
    end else if (load_c) begin
      sh_word_q <= fifo_data_c;
      sh_cnt_q  <= SC_W'(SPW);
    end else if (final_c) begin
      sh_cnt_q  <= '0;
    end else if (accept_c) begin
      sh_word_q <= sh_word_q << SYM_W;
      sh_cnt_q  <= sh_cnt_q - SC_W'(1);
    end
  end

`ifdef SYM_STREAM_STATS_EN
  logic [CNT_W-1:0] stall_q;
  logic             stall_c;

  assign stall_c   = (state_q == RUN) &&
                     (((pace_q == '0) && (sh_cnt_q == '0)) || (sym_valid && !sym_ready));
  assign stall_cnt = stall_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          stall_q <= '0;
    else if (start_c)                 stall_q <= '0;
    else if (stall_c && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_symbol_stream_src.sv
// Scoreboard bench for symbol_stream_src (SYM_W=2, WORD_W=8, DEPTH=4; RATE=2 main, RATE=1 second instance).
module tb_symbol_stream_src;

  localparam int unsigned CW = 16;

  typedef struct {
    logic [1:0] sym;
    logic       last;
    int         cyc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [CW-1:0] seq_len;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          sym_valid;
  logic          sym_ready;
  logic [1:0]    symbol;
  logic          sym_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] sym_count;

  logic          start1;
  logic          wr_valid1;
  logic          wr_ready1;
  logic          sym_valid1;
  logic [1:0]    symbol1;
  logic          sym_last1;
  logic          busy1;
  logic          done1;
  logic [CW-1:0] sym_count1;

`ifdef SYM_STREAM_STATS_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_cnt1;
`endif

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start_cyc = 0;
  exp_t exp_q[$];

  symbol_stream_src #(.SYM_W(2), .WORD_W(8), .DEPTH(4), .RATE(2), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .seq_len(seq_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .symbol(symbol), .sym_last(sym_last),
    .busy(busy), .done(done), .sym_count(sym_count)
`ifdef SYM_STREAM_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  symbol_stream_src #(.SYM_W(2), .WORD_W(8), .DEPTH(4), .RATE(1), .CNT_W(CW)) dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .seq_len(seq_len),
    .wr_valid(wr_valid1), .wr_data(wr_data), .wr_ready(wr_ready1),
    .sym_valid(sym_valid1), .sym_ready(1'b1), .symbol(symbol1), .sym_last(sym_last1),
    .busy(busy1), .done(done1), .sym_count(sym_count1)
`ifdef SYM_STREAM_STATS_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: pops on every accept, and checks that a stalled symbol holds steady.
  logic       hold_pend = 1'b0;
  logic [1:0] hold_sym  = '0;
  always @(negedge CLK) begin
    if (RST) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        total++;
        if (!(sym_valid && symbol == hold_sym)) begin
          bad++;
          $display("FAIL hold_stable: valid=%0b sym=%0d required valid=1 sym=%0d",
                   sym_valid, symbol, hold_sym);
        end
      end
      if (sym_valid && sym_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_symbol: sym=%0d at cycle %0d, none required", symbol,
                   cyc - start_cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (symbol !== e.sym || sym_last !== e.last ||
              (e.cyc >= 0 && (cyc - start_cyc) != e.cyc)) begin
            bad++;
            $display("FAIL stream_symbol: sym=%0d last=%0b cycle=%0d required sym=%0d last=%0b cycle=%0d",
                     symbol, sym_last, cyc - start_cyc, e.sym, e.last, e.cyc);
          end
        end
      end
      hold_pend = sym_valid && !sym_ready;
      hold_sym  = symbol;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wr(input logic [7:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    seq_len   = CW'(len);
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // Queue the symbols of one word, MSB first; cyc0<0 means timing not checked.
  task automatic push_word(input logic [7:0] w, input int n, input int cyc0,
                           input int step, input bit last_at_end);
    for (int j = 0; j < n; j++) begin
      exp_t e;
      e.sym  = w[7 - 2*j -: 2];
      e.last = last_at_end && (j == n - 1);
      e.cyc  = (cyc0 < 0) ? -1 : cyc0 + j * step;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int budget, input int req_cyc);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end else begin
      if (req_cyc >= 0) check({name, "_done_cycle"}, 32'(cyc - start_cyc), 32'(req_cyc));
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      tick();
      check({name, "_done_once"}, 32'(done), 32'd0);
    end
  endtask

  logic [7:0] words [4];

  initial begin
    RST = 1'b1; start = 1'b0; start1 = 1'b0; seq_len = '0;
    wr_valid = 1'b0; wr_valid1 = 1'b0; wr_data = '0; sym_ready = 1'b1;
    words[0] = 8'h1B; words[1] = 8'hE4; words[2] = 8'hC6; words[3] = 8'h39;
    tick();
    check("rst_valid", 32'(sym_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(sym_count), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_symbol_last", 32'({symbol, sym_last}), 32'd0);
    RST = 1'b0;
    tick();

    // RATE=1 instance: four words, 16 back-to-back symbols.
    for (int i = 0; i < 4; i++) begin
      wr_valid1 = 1'b1; wr_data = words[i]; tick();
    end
    wr_valid1 = 1'b0;
    check("r1_full", 32'(wr_ready1), 32'd0);
    start1 = 1'b1; seq_len = CW'(16); tick(); start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] w;
      tick();
      w = words[i / 4];
      check($sformatf("r1_sym%0d", i), 32'({sym_valid1, symbol1, sym_last1}),
            32'({1'b1, w[7 - 2*(i % 4) -: 2], i == 15}));
    end
    tick();
    check("r1_done", 32'({done1, busy1}), 32'b10);
    check("r1_count", 32'(sym_count1), 32'd16);

    // Basic stream.
    wr(8'h1B); wr(8'hE4);
    push_word(8'h1B, 4, 2, 2, 1'b0);
    push_word(8'hE4, 4, 10, 2, 1'b1);
    do_start(8);
    check("basic_busy", 32'(busy), 32'd1);
    wait_done("basic", 40, 17);
    check("basic_count", 32'(sym_count), 32'd8);

    // Partial word, leftovers discarded, then a one-symbol run.
    wr(8'h1B); wr(8'hE4);
    push_word(8'h1B, 4, 2, 2, 1'b0);
    push_word(8'hE4, 1, 10, 2, 1'b1);
    do_start(5);
    wait_done("partial", 40, 11);
    check("partial_count", 32'(sym_count), 32'd5);
    wr(8'hC0);
    push_word(8'hC0, 1, 2, 2, 1'b1);
    do_start(1);
    wait_done("single", 20, 3);
    check("single_count", 32'(sym_count), 32'd1);

    // Backpressure on the first symbol.
    sym_ready = 1'b0;
    wr(8'h1B);
    push_word(8'h1B, 4, -1, 2, 1'b1);
    do_start(4);
    for (int i = 0; i < 10 && !sym_valid; i++) tick();
    check("bp_valid_up", 32'(sym_valid), 32'd1);
    repeat (5) tick();
    check("bp_held", 32'({sym_valid, symbol}), 32'({1'b1, 2'd0}));
    sym_ready = 1'b1;
    wait_done("bp", 40, -1);
    check("bp_count", 32'(sym_count), 32'd4);

    // FIFO full; the fifth word must be dropped.
    for (int i = 0; i < 4; i++) wr(words[i]);
    check("full_ready", 32'(wr_ready), 32'd0);
    wr(8'hFF);
    check("full_still", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 4; i++) push_word(words[i], 4, 2 + 8*i, 2, i == 3);
    do_start(16);
    wait_done("full", 60, 33);
    check("full_drained", 32'(wr_ready), 32'd1);

    // Underflow: empty FIFO stalls, resumes two cycles after a write.
    do_start(4);
    repeat (6) tick();
    check("uf_stall", 32'({sym_valid, busy}), 32'b01);
    push_word(8'h1B, 4, 2, 2, 1'b1);
    start_cyc = cyc;
    wr(8'h1B);
    wait_done("uf", 30, -1);

    // Reset in the middle of a run.
    wr(8'h1B); wr(8'hE4);
    push_word(8'h1B, 3, 2, 2, 1'b0);
    do_start(8);
    for (int i = 0; i < 20 && sym_count != CW'(3); i++) tick();
    check("mid_count3", 32'(sym_count), 32'd3);
    RST = 1'b1;
    #1;
    check("mid_rst_outs", 32'({sym_valid, symbol, sym_last, busy, done}), 32'd0);
    check("mid_rst_count", 32'(sym_count), 32'd0);
    check("mid_rst_ready", 32'(wr_ready), 32'd1);
    tick();
    RST = 1'b0;
    tick();
    do_start(2);
    repeat (5) tick();
    check("post_rst_stall", 32'({sym_valid, busy}), 32'b01);
    RST = 1'b1; tick(); RST = 1'b0; tick();
    do_start(0);
    check("zero_len_done", 32'({done, busy, sym_valid}), 32'b100);
    check("zero_len_count", 32'(sym_count), 32'd0);
    tick();
    check("zero_len_idle", 32'(done), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
